// File: rtl/fu_div_pkg.sv
// Shared types and constant helpers for the iterative divide unit.
// Helpers are sized for operands up to MAX_WIDTH bits and narrowed by the user.
package fu_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int MAX_WIDTH = 64;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] all_ones(input int width);
        return (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] signed_min(input int width);
        return MAX_WIDTH'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor holds between steps, so a WIDTH+1 bit difference is enough
    // and its top bit is a reliable "went negative" flag.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {1'b0, divisor};
        quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
        if (diff[WIDTH]) begin
            rem_next = shifted[WIDTH-1:0];
        end else begin
            rem_next = diff[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fu_div_iter.sv
// Iterative signed/unsigned integer divider with tagging, flush and
// RISC-V divide-by-zero / overflow results. One operation in flight.
module fu_div_iter
    import fu_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EN,
    input  logic             flush,
    input  logic             is_signed,
    input  logic             rem_sel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [TAG_W-1:0] tag_in,
    output logic             ready,
    output logic             finish,
    output logic [WIDTH-1:0] res,
    output logic [TAG_W-1:0] tag_out,
    output logic             div_zero
);

    localparam int               CNT_W      = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] ONES       = WIDTH'(all_ones(WIDTH));
    localparam logic [WIDTH-1:0] SMIN       = WIDTH'(signed_min(WIDTH));
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;
    logic             q_neg;
    logic             r_neg;
    logic             rem_sel_r;
    logic [TAG_W-1:0] tag_r;

    logic             accept;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             b_zero;
    logic             overflow;
    logic             special;
    logic [WIDTH-1:0] special_res;
    logic             last_iter;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] quo_fixed;
    logic [WIDTH-1:0] rem_fixed;

    assign ready  = (state == IDLE) || (state == DONE);
    assign finish = (state == DONE);

    always_comb begin
        accept      = EN & ready & ~flush;
        a_neg       = is_signed & A[WIDTH-1];
        b_neg       = is_signed & B[WIDTH-1];
        a_mag       = a_neg ? -A : A;
        b_mag       = b_neg ? -B : B;
        b_zero      = (B == '0);
        overflow    = is_signed & (A == SMIN) & (B == ONES);
        special     = b_zero | overflow;
        // Overflow: quotient is the dividend itself, remainder is zero.
        if (b_zero) begin
            special_res = rem_sel ? A : ONES;
        end else begin
            special_res = rem_sel ? '0 : A;
        end
        last_iter   = (state == CALC) && (cnt == LAST_COUNT);
        quo_fixed   = q_neg ? -step_quo : step_quo;
        rem_fixed   = r_neg ? -step_rem : step_rem;
    end

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (div_r),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = special ? DONE : CALC;
            CALC: if (last_iter) state_next = DONE;
            DONE: begin
                if (accept) begin
                    state_next = special ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // Result registers move only on the edge that enters DONE; a flush leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            div_r     <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            rem_sel_r <= 1'b0;
            tag_r     <= '0;
            res       <= '0;
            tag_out   <= '0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            cnt       <= '0;
            rem_r     <= '0;
            quo_r     <= a_mag;
            div_r     <= b_mag;
            q_neg     <= a_neg ^ b_neg;
            r_neg     <= a_neg;
            rem_sel_r <= rem_sel;
            tag_r     <= tag_in;
            if (special) begin
                res      <= special_res;
                tag_out  <= tag_in;
                div_zero <= b_zero;
            end
        end else if ((state == CALC) && !flush) begin
            cnt   <= cnt + CNT_W'(1);
            rem_r <= step_rem;
            quo_r <= step_quo;
            if (last_iter) begin
                res      <= rem_sel_r ? rem_fixed : quo_fixed;
                tag_out  <= tag_r;
                div_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fu_div_iter.sv
// Self-checking bench for fu_div_iter: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_fu_div_iter;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam int LAT   = WIDTH + 1;

    logic             clk;
    logic             rst_n;
    logic             EN;
    logic             flush;
    logic             is_signed;
    logic             rem_sel;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [TAG_W-1:0] tag_in;
    logic             ready;
    logic             finish;
    logic [WIDTH-1:0] res;
    logic [TAG_W-1:0] tag_out;
    logic             div_zero;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] last_res;
    logic [TAG_W-1:0] last_tag;

    fu_div_iter #(
        .WIDTH(WIDTH),
        .TAG_W(TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .EN        (EN),
        .flush     (flush),
        .is_signed (is_signed),
        .rem_sel   (rem_sel),
        .A         (A),
        .B         (B),
        .tag_in    (tag_in),
        .ready     (ready),
        .finish    (finish),
        .res       (res),
        .tag_out   (tag_out),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic; C-style truncating division matches RISC-V.
    function automatic logic [WIDTH-1:0] ref_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                    input bit s, input bit r);
        longint sa, sb, q, rm;
        if (b == '0) return r ? a : {WIDTH{1'b1}};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q  = sa / sb;
        rm = sa % sb;
        return r ? rm[WIDTH-1:0] : q[WIDTH-1:0];
    endfunction

    function automatic bit ref_special(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit s);
        return (b == '0) || (s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    endfunction

    // Drives one request for a single edge; returns #1 after the accepting edge.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input bit s, input bit r, input logic [TAG_W-1:0] t);
        A = a; B = b; is_signed = s; rem_sel = r; tag_in = t; EN = 1'b1;
        @(posedge clk);
        #1;
        EN = 1'b0;
    endtask

    // Counts edges from the accepting edge (inclusive) until finish is seen.
    task automatic wait_finish(output int edges, output bit seen);
        edges = 1;
        seen  = 1'b0;
        while (!seen && edges <= 100) begin
            if (finish === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                edges++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; EN = 1'b0; flush = 1'b0; is_signed = 1'b0; rem_sel = 1'b0;
        A = '0; B = '0; tag_in = '0;
        #2 rst_n = 1'b0;
        #5;
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (finish !== 1'b0) begin errors++; $display("[TB] FAIL reset_finish: got %b expected 0", finish); end
        checks++; if (res !== '0) begin errors++; $display("[TB] FAIL reset_res: got %h expected 0", res); end
        checks++; if (tag_out !== '0) begin errors++; $display("[TB] FAIL reset_tag: got %h expected 0", tag_out); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_div_zero: got %b expected 0", div_zero); end
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        last_tag = '0;
    endtask

    task automatic test_unsigned();
        int edges; bit seen; logic [WIDTH-1:0] exp_res;
        for (int i = 0; i < 2; i++) begin
            exp_res = (i == 0) ? 32'd14 : 32'd2;
            @(negedge clk);
            start_op(32'd100, 32'd7, 1'b0, i[0], 5'd1);
            wait_finish(edges, seen);
            checks++; if (!seen || edges != LAT) begin errors++; $display("[TB] FAIL unsigned_latency[%0d]: got %0d edges expected %0d", i, edges, LAT); end
            checks++; if (res !== exp_res) begin errors++; $display("[TB] FAIL unsigned_res[%0d]: got %h expected %h", i, res, exp_res); end
            checks++; if (tag_out !== 5'd1) begin errors++; $display("[TB] FAIL unsigned_tag[%0d]: got %h expected 01", i, tag_out); end
            last_res = exp_res; last_tag = 5'd1;
        end
    endtask

    task automatic test_signed();
        int edges; bit seen; logic [WIDTH-1:0] exp_res;
        for (int i = 0; i < 2; i++) begin
            exp_res = (i == 0) ? 32'hFFFF_FFFD : 32'hFFFF_FFFF;
            @(negedge clk);
            start_op(32'hFFFF_FFF9, 32'd2, 1'b1, i[0], 5'd2);
            wait_finish(edges, seen);
            checks++; if (!seen || edges != LAT) begin errors++; $display("[TB] FAIL signed_latency[%0d]: got %0d edges expected %0d", i, edges, LAT); end
            checks++; if (res !== exp_res) begin errors++; $display("[TB] FAIL signed_res[%0d]: got %h expected %h", i, res, exp_res); end
            checks++; if (div_zero !== 1'b0) begin errors++; $display("[TB] FAIL signed_div_zero[%0d]: got %b expected 0", i, div_zero); end
            last_res = exp_res; last_tag = 5'd2;
        end
    endtask

    task automatic test_div_zero();
        int edges; bit seen; logic [WIDTH-1:0] exp_res;
        for (int i = 0; i < 2; i++) begin
            exp_res = (i == 0) ? 32'hFFFF_FFFF : 32'd5;
            @(negedge clk);
            start_op(32'd5, 32'd0, 1'b0, i[0], 5'd11);
            wait_finish(edges, seen);
            checks++; if (!seen || edges != 1) begin errors++; $display("[TB] FAIL div0_latency[%0d]: got %0d edges expected 1", i, edges); end
            checks++; if (res !== exp_res) begin errors++; $display("[TB] FAIL div0_res[%0d]: got %h expected %h", i, res, exp_res); end
            checks++; if (div_zero !== 1'b1) begin errors++; $display("[TB] FAIL div0_flag[%0d]: got %b expected 1", i, div_zero); end
            checks++; if (tag_out !== 5'd11) begin errors++; $display("[TB] FAIL div0_tag[%0d]: got %h expected 0b", i, tag_out); end
            last_res = exp_res; last_tag = 5'd11;
        end
    endtask

    task automatic test_overflow();
        int edges; bit seen; logic [WIDTH-1:0] exp_res;
        for (int i = 0; i < 2; i++) begin
            exp_res = (i == 0) ? 32'h8000_0000 : 32'd0;
            @(negedge clk);
            start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, i[0], 5'd12);
            wait_finish(edges, seen);
            checks++; if (!seen || edges != 1) begin errors++; $display("[TB] FAIL ovf_latency[%0d]: got %0d edges expected 1", i, edges); end
            checks++; if (res !== exp_res) begin errors++; $display("[TB] FAIL ovf_res[%0d]: got %h expected %h", i, res, exp_res); end
            checks++; if (div_zero !== 1'b0) begin errors++; $display("[TB] FAIL ovf_div_zero[%0d]: got %b expected 0", i, div_zero); end
            last_res = exp_res; last_tag = 5'd12;
        end
    endtask

    task automatic test_flush();
        int fin_count;
        @(negedge clk);
        start_op(32'd100, 32'd7, 1'b0, 1'b0, 5'd3);
        repeat (9) @(posedge clk);
        #1;
        // A special-case request in the flush cycle must lose to the flush.
        A = 32'd1; B = 32'd0; tag_in = 5'd20; EN = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        EN = 1'b0; flush = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready: got %b expected 1", ready); end
        checks++; if (finish !== 1'b0) begin errors++; $display("[TB] FAIL flush_finish: got %b expected 0", finish); end
        fin_count = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (finish === 1'b1) fin_count++;
        end
        checks++; if (fin_count != 0) begin errors++; $display("[TB] FAIL flush_no_finish: got %0d finish cycles expected 0", fin_count); end
        checks++; if (res !== last_res) begin errors++; $display("[TB] FAIL flush_res_held: got %h expected %h", res, last_res); end
        checks++; if (tag_out !== last_tag) begin errors++; $display("[TB] FAIL flush_tag_held: got %h expected %h", tag_out, last_tag); end
    endtask

    task automatic test_back_to_back();
        int edges; bit seen;
        @(negedge clk);
        start_op(32'd9, 32'd3, 1'b0, 1'b0, 5'd4);
        wait_finish(edges, seen);
        checks++; if (!seen || edges != LAT) begin errors++; $display("[TB] FAIL b2b_first_latency: got %0d edges expected %0d", edges, LAT); end
        checks++; if (res !== 32'd3) begin errors++; $display("[TB] FAIL b2b_first_res: got %h expected 3", res); end
        checks++; if (tag_out !== 5'd4) begin errors++; $display("[TB] FAIL b2b_first_tag: got %h expected 04", tag_out); end
        // Issued while finish is high, i.e. in the DONE cycle.
        start_op(32'd5, 32'd0, 1'b0, 1'b1, 5'd6);
        wait_finish(edges, seen);
        checks++; if (!seen || edges != 1) begin errors++; $display("[TB] FAIL b2b_special_latency: got %0d edges expected 1", edges); end
        checks++; if (res !== 32'd5 || div_zero !== 1'b1 || tag_out !== 5'd6) begin
            errors++; $display("[TB] FAIL b2b_special_out: got res %h dz %b tag %h expected 5 1 06", res, div_zero, tag_out);
        end
        start_op(32'd200, 32'd10, 1'b0, 1'b0, 5'd7);
        wait_finish(edges, seen);
        checks++; if (!seen || edges != LAT) begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d edges expected %0d", edges, LAT); end
        checks++; if (res !== 32'd20 || div_zero !== 1'b0 || tag_out !== 5'd7) begin
            errors++; $display("[TB] FAIL b2b_second_out: got res %h dz %b tag %h expected 14 0 07", res, div_zero, tag_out);
        end
        last_res = 32'd20; last_tag = 5'd7;
    endtask

    task automatic test_busy_ignore();
        int edges; bit seen;
        @(negedge clk);
        start_op(32'd1000, 32'd10, 1'b0, 1'b0, 5'd8);
        repeat (4) @(posedge clk);
        #1;
        A = 32'd5; B = 32'd0; tag_in = 5'd9; EN = 1'b1;
        @(posedge clk);
        #1;
        EN = 1'b0;
        checks++; if (finish !== 1'b0 || ready !== 1'b0) begin errors++; $display("[TB] FAIL busy_ignore_state: got finish %b ready %b expected 0 0", finish, ready); end
        wait_finish(edges, seen);
        checks++; if (!seen || res !== 32'd100 || tag_out !== 5'd8) begin
            errors++; $display("[TB] FAIL busy_ignore_res: got res %h tag %h expected 64 08", res, tag_out);
        end
        @(posedge clk);
        #1;
        checks++; if (finish !== 1'b0 || ready !== 1'b1) begin errors++; $display("[TB] FAIL busy_not_queued: got finish %b ready %b expected 0 1", finish, ready); end
        last_res = 32'd100; last_tag = 5'd8;
    endtask

    task automatic test_async_reset();
        int fin_count;
        @(negedge clk);
        start_op(32'd100, 32'd7, 1'b1, 1'b0, 5'd10);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b1 || finish !== 1'b0) begin errors++; $display("[TB] FAIL areset_ctrl: got ready %b finish %b expected 1 0", ready, finish); end
        checks++; if (res !== 32'd100 - 32'd100 + last_res - last_res) begin end
        checks--;
        checks++; if (res !== '0 || tag_out !== '0 || div_zero !== 1'b0) begin
            errors++; $display("[TB] FAIL areset_outputs: got res %h tag %h dz %b expected 0 0 0", res, tag_out, div_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fin_count = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (finish === 1'b1) fin_count++;
        end
        checks++; if (fin_count != 0) begin errors++; $display("[TB] FAIL areset_stale_finish: got %0d finish cycles expected 0", fin_count); end
        last_res = '0; last_tag = '0;
    endtask

    task automatic test_random();
        int edges, exp_lat, gap, sel;
        bit seen, s, r;
        logic [WIDTH-1:0] a, b, exp_res;
        logic [TAG_W-1:0] t;
        @(negedge clk);
        for (int n = 0; n < 60; n++) begin
            a = $urandom; b = $urandom;
            s = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            t = TAG_W'($urandom_range(0, 31));
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                b = '0;
            end else if (sel == 1) begin
                a = 32'h8000_0000; b = 32'hFFFF_FFFF;
            end else if (sel <= 4) begin
                b = $urandom_range(1, 15);
            end
            gap = $urandom_range(0, 2);
            repeat (gap) @(posedge clk);
            if (gap != 0) #1;
            exp_res = ref_result(a, b, s, r);
            exp_lat = ref_special(a, b, s) ? 1 : LAT;
            start_op(a, b, s, r, t);
            wait_finish(edges, seen);
            checks++; if (!seen || edges != exp_lat) begin errors++; $display("[TB] FAIL rand_latency[%0d]: got %0d edges expected %0d", n, edges, exp_lat); end
            checks++; if (res !== exp_res) begin
                errors++; $display("[TB] FAIL rand_res[%0d]: a %h b %h s %b r %b got %h expected %h", n, a, b, s, r, res, exp_res);
            end
            checks++; if (tag_out !== t) begin errors++; $display("[TB] FAIL rand_tag[%0d]: got %h expected %h", n, tag_out, t); end
            checks++; if (div_zero !== (b == '0)) begin errors++; $display("[TB] FAIL rand_div_zero[%0d]: got %b expected %b", n, div_zero, (b == '0)); end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_flush();
        test_back_to_back();
        test_busy_ignore();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fu_div_iter.md
# fu_div_iter

Parametrised iterative integer divide functional unit for the out-of-order core's execute stage. It replaces the vendor-IP-based divider with an in-house radix-2 restoring engine. It adds signed/unsigned and quotient/remainder modes, RISC-V divide-by-zero and overflow semantics, result tagging, a ready signal and pipeline flush. One operation is in flight at a time; the issue logic sees `ready` and a one-cycle `finish` pulse.

## Interface
- `WIDTH`, 32: operand and result width in bits (≥ 4).
- `TAG_W`, 5: width of the reservation-station tag carried with each operation.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `EN`  in  1  start request; accepted only when `ready` is high.
- `flush`  in  1  synchronous kill of the in-flight operation.
- `is_signed`  in  1  1 = two's-complement division, 0 = unsigned.
- `rem_sel`  in  1  1 = return remainder, 0 = return quotient.
- `A`  in  WIDTH  dividend.
- `B`  in  WIDTH  divisor.
- `tag_in`  in  TAG_W  tag captured with the operands.
- `ready`  out  1  unit can accept `EN` this cycle.
- `finish`  out  1  one-cycle pulse; `res`, `tag_out` and `div_zero` are valid.
- `res`  out  WIDTH  selected result, held until the next `finish`.
- `tag_out`  out  TAG_W  tag of the finished operation.
- `div_zero`  out  1  finished operation had `B == 0`.

## Operation
- States: IDLE, CALC, DONE.
- Reset values: state IDLE, `ready`=1, `finish`=0, `res`=0, `tag_out`=0, `div_zero`=0, iteration counter 0.
- `ready` = (state is IDLE or DONE), so back-to-back issue is possible from DONE.
- Acceptance (`EN & ready & ~flush`) latches the following: `tag_in`, mode bits, and |A| and |B| (magnitudes when `is_signed`, else raw). It also latches the quotient sign (sign(A) XOR sign(B)) and the remainder sign (sign(A)).
- Special cases are decided at acceptance and go straight to DONE with no CALC cycles:
  - `B == 0`: quotient = all ones, remainder = A, `div_zero`=1.
  - `is_signed` and A = 2^(WIDTH-1) and B = all ones: quotient = A, remainder = 0.
- Normal case enters CALC and runs WIDTH restoring iterations, MSB first. Each iteration shifts {rem, quo} left by 1, trial-subtracts |B| (width WIDTH+1), and keeps the difference and sets the quotient bit if it is non-negative.
- The last CALC iteration applies the sign corrections (negate the quotient if its sign bit is set, negate the remainder if its sign bit is set), selects per `rem_sel`, registers `res`, and moves to DONE.
- DONE lasts one cycle with `finish`=1, then returns to IDLE. An accept in DONE goes to CALC or DONE per the rules above.
- `EN` while `ready` is 0 is ignored and not queued.
- `flush`: next state is IDLE, no `finish`, and `res`/`tag_out` keep their old values. `flush` has priority over `EN` in the same cycle. A `flush` during DONE does not cancel the `finish` already asserted that cycle.
- `rst_n` low mid-operation aborts immediately to the reset values.

## Timing
- Normal op: accepted at edge k; `finish` is high in the cycle after edge k+WIDTH (WIDTH+1 edges of latency).
- Special case: `finish` is high in the cycle after edge k (1 edge of latency).
- Throughput: one op per WIDTH+1 cycles normal, one per cycle for back-to-back special cases.
- `res`, `tag_out` and `div_zero` change only on the edge that raises `finish`.

## Structure
- Package `fu_div_pkg`:
  - state enum (IDLE, CALC, DONE)
  - counter width `$clog2(WIDTH+1)` as a function
  - special-case constant helpers (all-ones, signed-min)
- Sub-module `div_step`: combinational single restoring iteration (inputs rem, quo, divisor; outputs next rem, next quo), parametrised by WIDTH.
- The top level holds the FSM, counter, operand/sign registers and output registers.

## Test plan
- Unsigned A=100, B=7, quotient: `finish` 33 edges after accept, `res`=14; repeat with `rem_sel`=1: `res`=2.
- Signed A=-7 (0xFFFFFFF9), B=2: quotient `res`=0xFFFFFFFD (-3); remainder `res`=0xFFFFFFFF (-1).
- A=5, B=0: `finish` 1 edge after accept, `res`=0xFFFFFFFF, `div_zero`=1; with `rem_sel`=1, `res`=5.
- Signed A=0x80000000, B=0xFFFFFFFF: 1-edge latency, quotient 0x80000000, remainder 0, `div_zero`=0.
- Flush 10 cycles into an op with tag 3: no `finish`, `ready`=1 next cycle. Then 9/3 with tag 4 gives `res`=3, `tag_out`=4. `EN` asserted in the DONE cycle is accepted (back-to-back).
- `rst_n` pulsed low mid-CALC: all outputs return to reset values asynchronously, `ready`=1, and no stale `finish` follows.
